event_trigger_out: RTL and testbench

EVENT_TRIGGER_OUT -- requirements
Module: event_trigger_out

---
 rtl/event_trigger_pkg.sv | 9 +
 rtl/event_debounce.sv | 57 +++++
 rtl/event_trigger_out.sv | 67 ++++++
 tb/tb_event_trigger_out.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/event_trigger_pkg.sv
// Shared constants for the event trigger-out block: default channel count,
// default debounce length and the width of the per-channel debounce counter.
package event_trigger_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_DEB_LIMIT = 200;
  localparam int DEB_CNT_W     = 8;

endpackage

// File: rtl/event_debounce.sv
// One event channel: 2-flop synchronizer followed by an optional debounce
// filter, enabled by the EVENT_TRIGGER_DEBOUNCE_EN macro.
module event_debounce
  import event_trigger_pkg::*;
`ifdef EVENT_TRIGGER_DEBOUNCE_EN
#(
  parameter int DEB_LIMIT = DEF_DEB_LIMIT
)
`endif
(
  input  logic clk1,
  input  logic reset,
  input  logic din,
  output logic filt
);

  logic s1;
  logic s2;

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

`ifdef EVENT_TRIGGER_DEBOUNCE_EN
  localparam logic [DEB_CNT_W-1:0] CNT_TOP = DEB_CNT_W'(DEB_LIMIT - 1);

  logic [DEB_CNT_W-1:0] cnt;
  logic                 filt_q;

  // The counter only runs while s2 disagrees with the filtered level, so any
  // return to agreement before CNT_TOP discards the glitch.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      filt_q <= 1'b0;
    end else if (s2 == filt_q) begin
      cnt <= '0;
    end else if (cnt == CNT_TOP) begin
      filt_q <= s2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign filt = filt_q;
`else
  assign filt = s2;
`endif

endmodule

// File: rtl/event_trigger_out.sv
// Captures rising edges on asynchronous event inputs into sticky pending bits
// and hands them to the host as snapshots. Debounce: EVENT_TRIGGER_DEBOUNCE_EN.
module event_trigger_out
  import event_trigger_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEB_LIMIT = DEF_DEB_LIMIT
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic [WIDTH-1:0] event_in,
  input  logic             update_req,
  output logic [WIDTH-1:0] trig_word,
  output logic [WIDTH-1:0] ovf_word,
  output logic             update_ack,
  output logic             pending_any
);

  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] ovf;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
`ifdef EVENT_TRIGGER_DEBOUNCE_EN
    event_debounce #(.DEB_LIMIT(DEB_LIMIT)) u_deb (
`else
    event_debounce u_deb (
`endif
      .clk1  (clk1),
      .reset (reset),
      .din   (event_in[i]),
      .filt  (filt[i])
    );
  end

  assign rise        = filt & ~prev;
  assign pending_any = |pending;

  // Handshake: update_req is a one-cycle strobe; update_ack pulses the next
  // cycle, and trig_word/ovf_word are valid from then until the next strobe.
  // A rise coinciding with the strobe goes straight into the snapshot.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      prev       <= '0;
      pending    <= '0;
      ovf        <= '0;
      trig_word  <= '0;
      ovf_word   <= '0;
      update_ack <= 1'b0;
    end else begin
      prev       <= filt;
      update_ack <= update_req;
      if (update_req) begin
        trig_word <= pending | rise;
        ovf_word  <= ovf | (rise & pending);
        pending   <= '0;
        ovf       <= '0;
      end else begin
        pending <= pending | rise;
        ovf     <= ovf | (rise & pending);
      end
    end
  end

endmodule

// File: tb/tb_event_trigger_out.sv
// Directed bench for event_trigger_out (WIDTH=16, DEB_LIMIT=4); honours the
// EVENT_TRIGGER_DEBOUNCE_EN macro for filter-dependent latencies and cases.
module tb_event_trigger_out;

  localparam int WIDTH     = 16;
  localparam int DEB_LIMIT = 4;
`ifdef EVENT_TRIGGER_DEBOUNCE_EN
  localparam int LAT  = 3 + DEB_LIMIT;
  localparam int HOLD = DEB_LIMIT + 2;
`else
  localparam int LAT  = 3;
  localparam int HOLD = 2;
`endif

  logic             clk1 = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] event_in;
  logic             update_req;
  logic [WIDTH-1:0] trig_word;
  logic [WIDTH-1:0] ovf_word;
  logic             update_ack;
  logic             pending_any;

  int tests_run = 0;
  int failed    = 0;

  event_trigger_out #(.WIDTH(WIDTH), .DEB_LIMIT(DEB_LIMIT)) dut (
    .clk1        (clk1),
    .reset       (reset),
    .event_in    (event_in),
    .update_req  (update_req),
    .trig_word   (trig_word),
    .ovf_word    (ovf_word),
    .update_ack  (update_ack),
    .pending_any (pending_any)
  );

  always #5 clk1 = ~clk1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk1);
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobe for one clock; returns at the negedge after the capturing edge.
  task automatic do_update();
    update_req = 1'b1;
    tick(1);
    update_req = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    event_in   = '0;
    update_req = 1'b0;
    tick(2);
    check("rst_trig", trig_word, 16'h0000);
    check("rst_ovf", ovf_word, 16'h0000);
    check("rst_ack", {15'b0, update_ack}, 16'h0000);
    check("rst_pend", {15'b0, pending_any}, 16'h0000);
    reset = 1'b0;
    tick(2);

    // Single rising edge on channel 3
    event_in[3] = 1'b1;
    tick(LAT - 1);
    check("c3_pend_early", {15'b0, pending_any}, 16'h0000);
    tick(1);
    check("c3_pend", {15'b0, pending_any}, 16'h0001);
    do_update();
    check("c3_trig", trig_word, 16'h0008);
    check("c3_ovf", ovf_word, 16'h0000);
    check("c3_ack", {15'b0, update_ack}, 16'h0001);
    check("c3_pend_clr", {15'b0, pending_any}, 16'h0000);
    tick(1);
    check("c3_ack_low", {15'b0, update_ack}, 16'h0000);
    check("c3_trig_hold", trig_word, 16'h0008);

    // Two rises on channel 5 before the host reads -> overflow
    event_in[5] = 1'b1;
    tick(HOLD);
    event_in[5] = 1'b0;
    tick(HOLD);
    event_in[5] = 1'b1;
    tick(LAT + 1);
    do_update();
    check("c5_trig", trig_word, 16'h0020);
    check("c5_ovf", ovf_word, 16'h0020);
    do_update();
    check("c5_trig_b2b", trig_word, 16'h0000);
    check("c5_ovf_b2b", ovf_word, 16'h0000);
    check("c5_ack_b2b", {15'b0, update_ack}, 16'h0001);
    event_in[5] = 1'b0;
    tick(HOLD + 4);

    // Rise on channel 7 coinciding with the strobe
    event_in[7] = 1'b1;
    tick(LAT - 1);
    do_update();
    check("c7_trig", trig_word, 16'h0080);
    check("c7_ovf", ovf_word, 16'h0000);
    check("c7_pend", {15'b0, pending_any}, 16'h0000);
    tick(2);
    check("c7_pend_later", {15'b0, pending_any}, 16'h0000);

    // Reset mid-operation discards captured events
    event_in[2:1] = 2'b11;
    tick(LAT + 1);
    check("mid_pend", {15'b0, pending_any}, 16'h0001);
    reset = 1'b1;
    #1;
    check("mid_async_trig", trig_word, 16'h0000);
    check("mid_async_pend", {15'b0, pending_any}, 16'h0000);
    tick(1);
    update_req = 1'b1;
    tick(1);
    update_req = 1'b0;
    check("mid_req_in_rst", {15'b0, update_ack}, 16'h0000);
    event_in = '0;
    tick(2);
    reset = 1'b0;
    tick(LAT + 2);
    check("mid_pend_after", {15'b0, pending_any}, 16'h0000);
    do_update();
    check("mid_trig", trig_word, 16'h0000);
    check("mid_ovf", ovf_word, 16'h0000);

    // All inputs high through reset release -> exactly one event each
    reset    = 1'b1;
    event_in = 16'hFFFF;
    tick(2);
    reset = 1'b0;
    tick(LAT - 1);
    check("all_pend_early", {15'b0, pending_any}, 16'h0000);
    tick(1);
    check("all_pend", {15'b0, pending_any}, 16'h0001);
    do_update();
    check("all_trig", trig_word, 16'hFFFF);
    check("all_ovf", ovf_word, 16'h0000);
    tick(LAT + 3);
    check("all_no_repeat", {15'b0, pending_any}, 16'h0000);
    do_update();
    check("all_trig2", trig_word, 16'h0000);
    event_in = '0;
    tick(HOLD + 4);

`ifdef EVENT_TRIGGER_DEBOUNCE_EN
    // Glitch shorter than the debounce window is dropped
    event_in[0] = 1'b1;
    tick(3);
    event_in[0] = 1'b0;
    tick(DEB_LIMIT + 6);
    check("deb_short_pend", {15'b0, pending_any}, 16'h0000);
    do_update();
    check("deb_short_trig", trig_word, 16'h0000);
    // Long pulse passes
    event_in[0] = 1'b1;
    tick(6);
    event_in[0] = 1'b0;
    tick(LAT + 2);
    do_update();
    check("deb_long_trig", trig_word, 16'h0001);
`else
    // Without filtering a single-cycle pulse is captured
    event_in[0] = 1'b1;
    tick(1);
    event_in[0] = 1'b0;
    tick(LAT + 1);
    check("pulse_pend", {15'b0, pending_any}, 16'h0001);
    do_update();
    check("pulse_trig", trig_word, 16'h0001);
`endif
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
